// File: rtl/encoder_42_fifo.sv
// Sequential 4-to-2 priority encoder. Rising edges on D3..D0 are encoded,
// queued in a circular FIFO and delivered over a V/RDY handshake.
module encoder_42_fifo #(
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            D3,
   input  logic            D2,
   input  logic            D1,
   input  logic            D0,
   input  logic            RDY,
   output logic            Y1,
   output logic            Y0,
   output logic            V,
   output logic            MULTI,
   output logic            OVF,
   output logic [CNTW-1:0] CNT
);

   localparam int AW = $clog2(DEPTH);

   function automatic logic [1:0] prio_code(input logic [3:0] e);
      logic [1:0] c;
      if (e[3])      c = 2'b11;
      else if (e[2]) c = 2'b10;
      else if (e[1]) c = 2'b01;
      else           c = 2'b00;
      return c;
   endfunction

   // True when two or more bits are set (clearing the lowest set bit leaves a remainder).
   function automatic logic many_set(input logic [3:0] e);
      return (e & (e - 4'd1)) != 4'd0;
   endfunction

   logic [3:0]      p_q, p_d;
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            v_q, v_d, ovf_q, ovf_d, multi_q, multi_d;
   logic [1:0]      y_q, y_d;
   logic [1:0]      mem_q [DEPTH];
   logic [1:0]      mem_d [DEPTH];

   logic [3:0]      edge_s;
   logic            push_s, pop_s, full_s, accept_s;

   // Edge detect, push/pop arbitration and next-state of the queue and outputs.
   always_comb begin
      edge_s   = {D3, D2, D1, D0} & ~p_q;
      push_s   = (edge_s != 4'b0000);
      pop_s    = v_q & RDY;
      full_s   = (cnt_q == CNTW'(DEPTH));
      accept_s = push_s & (~full_s | pop_s);

      p_d     = {D3, D2, D1, D0};
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      ovf_d   = ovf_q;
      multi_d = many_set(edge_s);

      if (accept_s) begin
         mem_d[wp_q] = prio_code(edge_s);
         wp_d        = wp_q + 1'b1;
      end else begin
         wp_d = wp_q;
      end

      if (pop_s) begin
         rp_d = rp_q + 1'b1;
      end else begin
         rp_d = rp_q;
      end

      if (push_s && full_s && !pop_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end

      case ({accept_s, pop_s})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Head is registered from the post-update state, so it never bypasses the input edge.
      v_d = (cnt_d != '0);
      if (v_d) begin
         y_d = mem_d[rp_d];
      end else begin
         y_d = 2'b00;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         p_q     <= 4'b1111;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         v_q     <= 1'b0;
         y_q     <= 2'b00;
         ovf_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         v_q     <= v_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
         multi_q <= multi_d;
      end
   end

   // Storage array; contents are never visible after reset so it carries none.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign Y1    = y_q[1];
   assign Y0    = y_q[0];
   assign V     = v_q;
   assign MULTI = multi_q;
   assign OVF   = ovf_q;
   assign CNT   = cnt_q;

endmodule

// File: doc/encoder_42_fifo.md
# encoder_42_fifo

Sequential 4-to-2 priority encoder with an event queue; the inverse of the team's 2-to-4 decoder. It watches four request lines D3..D0, such as lab-board buttons or decoder outputs looped back. Each rising edge on a line becomes a 2-bit code, which is buffered in a small FIFO and delivered to a downstream consumer over a valid/ready handshake. Overflow and multi-edge conditions are flagged.

## Interface
- DEPTH, 4, FIFO entries; power of 2, minimum 2
- CNTW, log2(DEPTH)+1, width of the occupancy count
- CLK  input  1  clock; all state changes on the rising edge
- RST_N  input  1  reset, synchronous, active-low
- D3, D2, D1, D0  input  1 each  request lines, synchronous to CLK
- Y1, Y0  output  1 each  encoded code at the FIFO head (Y1 = MSB)
- V  output  1  head entry valid (FIFO non-empty)
- RDY  input  1  consumer ready; an entry pops when V && RDY
- MULTI  output  1  one-cycle pulse: more than one rising edge was detected in the same cycle
- OVF  output  1  sticky: an event was dropped because the FIFO was full
- CNT  output  CNTW  current FIFO occupancy, 0..DEPTH

## Operation
- Edge detect:
  - A register P[3:0] holds the previous sample of D3..D0.
  - E = {D3,D2,D1,D0} & ~P.
  - P <= {D3..D0} every cycle.
- Encode: if any E bit is set, code = index of the highest set bit (D3 -> 2'b11, D2 -> 2'b10, D1 -> 2'b01, D0 -> 2'b00).
  - Only that one event is offered for push.
  - Lower simultaneous edges are discarded, and MULTI = 1 on the next cycle.
- push = (E != 0). pop = V && RDY.
- Push rules:
  - Not full: push is accepted.
  - Full with pop in the same cycle: push is accepted; CNT stays DEPTH.
  - Full without pop: push is dropped, OVF <= 1, FIFO contents unchanged.
- Pop with no push: CNT decrements. Push and pop together when not empty or full: CNT unchanged.
- Storage is a circular buffer with write pointer WP and read pointer RP of width log2(DEPTH). Both wrap from DEPTH-1 to 0.
- Order is strictly FIFO; codes are stored exactly as encoded.
- Y1, Y0 = mem[RP] whenever V = 1. When V = 0, Y1 = Y0 = 0.
- V = (CNT != 0).
- OVF clears only on reset.
- Reset (RST_N = 0 sampled at any rising edge, including mid-operation):
  - CNT = 0, WP = RP = 0, V = 0, Y1 = Y0 = 0, MULTI = 0, OVF = 0.
  - P = 4'b1111, so lines already high at reset release do not generate events.
  - Edges present during the reset cycle are ignored.
  - FIFO contents after reset are don't-care and never visible.

## Timing
- Latency: D rises and is first sampled high at edge n. The code is written at edge n, and V = 1 with a valid code from edge n onward (cycle n+1) when the FIFO was empty.
- There is no bypass path: V never rises in the same cycle as the input edge.
- Pop: if V && RDY at edge m, the head is consumed at edge m. The next entry, or V = 0, is presented after edge m.
- Backpressure: while V && !RDY, Y1/Y0 and V are held stable.
- A line held high produces exactly one event. It must return low for at least one sampled cycle before it can generate another.
- MULTI asserts for exactly one cycle, aligned with the push edge, and regardless of whether that push was dropped.
- Throughput: one push and one pop per cycle maximum.

## Test plan
1. Reset, then D1 pulses high for 1 cycle -> one cycle later V = 1, Y = 01, CNT = 1. With RDY = 1 -> V = 0 and CNT = 0 after the next edge.
2. D3 and D0 rise in the same cycle, RDY = 0 -> a single entry Y = 11, CNT = 1, MULTI pulses for exactly 1 cycle, no 00 entry queued.
3. RDY = 0; edges on D0, D1, D2, D3, D2 in separate cycles (DEPTH = 4) -> CNT = 4, OVF = 1 after the 5th edge. Then RDY = 1 drains 00, 01, 10, 11 in order; OVF stays 1.
4. FIFO full, RDY = 1, new D2 edge in the same cycle as a pop -> no overflow, CNT stays 4, OVF stays 0, and the 10 appears last in drain order.
5. Hold D1 high for 10 cycles, drop it, then raise it again -> exactly two 01 entries. D0 held high across reset release -> no entry.
6. With 3 entries queued and OVF = 1, assert RST_N = 0 for one edge while D2 rises -> CNT = 0, V = 0, OVF = 0, MULTI = 0 the next cycle, and no entry is queued.
